// File: rtl/oc8051_cxrom_fetch_if.sv
// Bus bundle between the code-ROM fetch unit, the combinational code ROM and the decoder.
// slave = fetch unit view, master = ROM/decoder side.
interface oc8051_cxrom_fetch_if;
   logic        fetch_en;
   logic [15:0] cxrom_addr;
   logic [31:0] cxrom_data_in;
   logic        jmp_valid;
   logic [15:0] jmp_addr;
   logic        byte_rd;
   logic        byte_valid;
   logic [7:0]  byte_out;
   logic [15:0] byte_pc;

   modport slave (
      input  fetch_en, cxrom_data_in, jmp_valid, jmp_addr, byte_rd,
      output cxrom_addr, byte_valid, byte_out, byte_pc
   );

   modport master (
      output fetch_en, cxrom_data_in, jmp_valid, jmp_addr, byte_rd,
      input  cxrom_addr, byte_valid, byte_out, byte_pc
   );
endinterface

// File: rtl/oc8051_cxrom_fetch.sv
// oc8051 code-ROM fetch unit: 32-bit ROM words are split into a byte queue for the decoder.
// Build option OC8051_CXROM_PREFETCH_EN deepens the queue to 8 so fetch overlaps consumption.
module oc8051_cxrom_fetch (
   input  logic                 clk,
   input  logic                 rst,
   oc8051_cxrom_fetch_if.slave  bus
);

`ifdef OC8051_CXROM_PREFETCH_EN
   localparam int unsigned QD = 8;
`else
   localparam int unsigned QD = 4;
`endif
   localparam int unsigned IW       = $clog2(QD);
   localparam logic [3:0]  PUSH_MAX = 4'(QD - 4);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t      state_q, state_d;
   logic [7:0]  q_q [QD];
   logic [7:0]  q_d [QD];
   logic [3:0]  count_q, count_d;
   logic [15:0] ptr_q, ptr_d;
   logic [15:0] pc_q, pc_d;
   logic        pop, push;
   logic [3:0]  wr_base;

   assign pop     = bus.byte_rd && (count_q != '0);
   assign push    = (state_q == S_RUN) && bus.fetch_en && !bus.jmp_valid && (count_q <= PUSH_MAX);
   assign wr_base = count_q - {3'b000, pop};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (bus.fetch_en)  state_d = S_RUN;
         S_RUN:  if (!bus.fetch_en) state_d = S_IDLE;
      endcase
   end

   // Head sits at q[0]; a pop shifts down first, so the new word lands after the survivors.
   always_comb begin
      q_d     = q_q;
      count_d = count_q;
      ptr_d   = ptr_q;
      pc_d    = pc_q;
      if (bus.jmp_valid) begin
         count_d = '0;
         ptr_d   = bus.jmp_addr;
         pc_d    = bus.jmp_addr;
      end else begin
         if (pop) begin
            for (int unsigned i = 0; i < QD - 1; i++) q_d[i] = q_q[i + 1];
            pc_d = pc_q + 16'd1;
         end
         if (push) begin
            for (int unsigned k = 0; k < 4; k++)
               q_d[IW'(wr_base) + IW'(k)] = bus.cxrom_data_in[8*k +: 8];
            ptr_d = ptr_q + 16'd4;
         end
         count_d = count_q + (push ? 4'd4 : 4'd0) - {3'b000, pop};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         ptr_q   <= '0;
         pc_q    <= '0;
         for (int unsigned i = 0; i < QD; i++) q_q[i] <= '0;
      end else begin
         count_q <= count_d;
         ptr_q   <= ptr_d;
         pc_q    <= pc_d;
         q_q     <= q_d;
      end
   end

   assign bus.cxrom_addr = ptr_q;
   assign bus.byte_valid = (count_q != '0);
   assign bus.byte_out   = q_q[0];
   assign bus.byte_pc    = pc_q;

endmodule
